// File: rtl/toggle_chk_pkg.sv
// Shared types and constants for the toggle pattern checker.
// Holds the FSM encoding, default parameters and the cycle-counter width helper.
package toggle_chk_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        ACQUIRE = 2'd2,
        LOCKED  = 2'd3
    } chk_state_t;

    localparam int DEF_HALF_PERIOD  = 2;
    localparam int DEF_LOCK_TOGGLES = 4;
    localparam int DEF_MAX_ERR_RUN  = 3;
    localparam int DEF_ERR_W        = 8;
    localparam int DEF_GOOD_W       = 16;

    // The counter saturates at half_period+1, so it must be able to hold that value.
    function automatic int cnt_width(input int half_period);
        return $clog2(half_period + 2);
    endfunction

endpackage

// File: rtl/toggle_pattern_checker_edge.sv
// Input sampling stage: registers the monitored line and flags any change
// between the current sample and the previous one.
module edge_detect_reg (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic edge_det
);

    logic d_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q_reg <= 1'b0;
        end else begin
            d_q_reg <= d_in;
        end
    end

    assign edge_det = d_in ^ d_q_reg;

endmodule

// File: rtl/toggle_pattern_checker.sv
// Locks onto a fixed half-period square wave on d_in, then reports early and
// missing edges as strobes and counts good edges and errors.
module toggle_pattern_checker
    import toggle_chk_pkg::*;
#(
    parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
    parameter int LOCK_TOGGLES = DEF_LOCK_TOGGLES,
    parameter int MAX_ERR_RUN  = DEF_MAX_ERR_RUN,
    parameter int ERR_W        = DEF_ERR_W,
    parameter int GOOD_W       = DEF_GOOD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              d_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [GOOD_W-1:0] good_count
);

    localparam int CNT_W = cnt_width(HALF_PERIOD);
    localparam int GR_W  = $clog2(LOCK_TOGGLES + 1);
    localparam int ER_W  = $clog2(MAX_ERR_RUN + 1);

    localparam logic [CNT_W-1:0] CNT_HP  = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(HALF_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GR_W-1:0]  GR_LAST = GR_W'(LOCK_TOGGLES - 1);
    localparam logic [ER_W-1:0]  ER_LAST = ER_W'(MAX_ERR_RUN - 1);

    chk_state_t         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic [GR_W-1:0]    good_run_reg;
    logic [ER_W-1:0]    err_run_reg;
    logic [ERR_W-1:0]   err_count_reg;
    logic [ERR_W-1:0]   err_count_next;
    logic [GOOD_W-1:0]  good_count_reg;
    logic               locked_reg;
    logic               err_pulse_reg;

    logic               edge_det;
    logic               cnt_at_hp;
    logic               cnt_over;
    logic               checking;
    logic               good_edge;
    logic               err_det;

    edge_detect_reg u_edge (
        .clk      (clk),
        .reset    (reset),
        .d_in     (d_in),
        .edge_det (edge_det)
    );

    // Classify the current sample against the registered cycle count.
    always_comb begin
        cnt_at_hp = (cnt_reg == CNT_HP);
        cnt_over  = (cnt_reg > CNT_HP);
        checking  = enable && (state_reg == LOCKED);
        good_edge = checking && edge_det && cnt_at_hp;
        // Inside LOCKED the count never exceeds HALF_PERIOD, so an edge that is
        // not on time is early, and reaching HALF_PERIOD without one is a miss.
        err_det   = checking && (edge_det ? !cnt_at_hp : cnt_at_hp);
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (edge_det || err_det) begin
            cnt_next = CNT_ONE;
        end else if (cnt_reg != CNT_SAT) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_comb begin
        err_count_next = err_count_reg;
        if (clr_err) begin
            err_count_next = err_det ? ERR_W'(1) : '0;
        end else if (err_det && (err_count_reg != {ERR_W{1'b1}})) begin
            err_count_next = err_count_reg + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            good_run_reg   <= '0;
            err_run_reg    <= '0;
            err_count_reg  <= '0;
            good_count_reg <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            err_count_reg <= err_count_next;
            err_pulse_reg <= err_det;
            if (good_edge) begin
                good_count_reg <= good_count_reg + GOOD_W'(1);
            end

            if (!enable) begin
                state_reg    <= IDLE;
                good_run_reg <= '0;
                err_run_reg  <= '0;
                locked_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= SEARCH;
                    end
                    SEARCH: begin
                        if (edge_det) begin
                            state_reg    <= ACQUIRE;
                            good_run_reg <= '0;
                        end
                    end
                    ACQUIRE: begin
                        // A late edge restarts acquisition just as a fresh edge
                        // in SEARCH would; a timeout without one drops back.
                        if (cnt_over) begin
                            if (edge_det) begin
                                good_run_reg <= '0;
                            end else begin
                                state_reg <= SEARCH;
                            end
                        end else if (edge_det) begin
                            if (!cnt_at_hp) begin
                                good_run_reg <= '0;
                            end else if (good_run_reg == GR_LAST) begin
                                state_reg    <= LOCKED;
                                locked_reg   <= 1'b1;
                                good_run_reg <= '0;
                                err_run_reg  <= '0;
                            end else begin
                                good_run_reg <= good_run_reg + GR_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (good_edge) begin
                            err_run_reg <= '0;
                        end else if (err_det) begin
                            if (err_run_reg == ER_LAST) begin
                                state_reg   <= SEARCH;
                                locked_reg  <= 1'b0;
                                err_run_reg <= '0;
                            end else begin
                                err_run_reg <= err_run_reg + ER_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_count  = err_count_reg;
    assign good_count = good_count_reg;

endmodule

// File: tb/tb_toggle_pattern_checker.sv
// Directed and randomized bench for toggle_pattern_checker, compared every cycle
// against a timestamp-based reference model of the checker's rules.
module tb_toggle_pattern_checker;

    localparam int HP       = 2;
    localparam int LT       = 4;
    localparam int MER      = 3;
    localparam int ERR_W    = 8;
    localparam int GOOD_W   = 16;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int GOOD_MOD = 1 << GOOD_W;

    localparam int M_OFF  = 0;
    localparam int M_HUNT = 1;
    localparam int M_ACQ  = 2;
    localparam int M_LOCK = 3;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              enable  = 1'b0;
    logic              d_in    = 1'b0;
    logic              clr_err = 1'b0;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [GOOD_W-1:0] good_count;

    toggle_pattern_checker #(
        .HALF_PERIOD  (HP),
        .LOCK_TOGGLES (LT),
        .MAX_ERR_RUN  (MER),
        .ERR_W        (ERR_W),
        .GOOD_W       (GOOD_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .d_in       (d_in),
        .clr_err    (clr_err),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .good_count (good_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: time is kept as absolute cycle numbers; "since" is the
    // number of cycles elapsed from the last edge (or flywheel) reference point.
    int   mode     = M_OFF;
    int   cyc      = 0;
    int   ref_cyc  = 0;
    int   good_run = 0;
    int   err_run  = 0;
    int   exp_err  = 0;
    int   exp_good = 0;
    bit   prev_d   = 1'b0;
    bit   exp_lock = 1'b0;
    bit   exp_pulse = 1'b0;

    logic d_cur       = 1'b0;
    int   pulses_seen = 0;
    int   first_lock  = -1;
    int   s0          = 0;
    int   gap_left    = 1;
    bit   en_r, clr_r, rst_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input bit en, input bit d, input bit clr, input bit rst);
        bit tog, err;
        int since;
        if (rst) begin
            mode      = M_OFF;
            prev_d    = 1'b0;
            ref_cyc   = cyc + 1;
            good_run  = 0;
            err_run   = 0;
            exp_lock  = 1'b0;
            exp_pulse = 1'b0;
            exp_err   = 0;
            exp_good  = 0;
        end else begin
            tog   = (d != prev_d);
            since = cyc - ref_cyc;
            if (since > HP + 1) since = HP + 1;
            err = 1'b0;
            if (!en) begin
                mode     = M_OFF;
                good_run = 0;
                err_run  = 0;
                exp_lock = 1'b0;
            end else if (mode == M_OFF) begin
                mode = M_HUNT;
            end else if (mode == M_HUNT) begin
                if (tog) begin
                    mode     = M_ACQ;
                    good_run = 0;
                end
            end else if (mode == M_ACQ) begin
                if (since > HP) begin
                    if (tog) good_run = 0;
                    else     mode = M_HUNT;
                end else if (tog) begin
                    if (since == HP) begin
                        good_run++;
                        if (good_run == LT) begin
                            mode     = M_LOCK;
                            exp_lock = 1'b1;
                            good_run = 0;
                            err_run  = 0;
                        end
                    end else begin
                        good_run = 0;
                    end
                end
            end else begin
                if (tog && since == HP) begin
                    exp_good = (exp_good + 1) % GOOD_MOD;
                    err_run  = 0;
                end else if (tog || since == HP) begin
                    err = 1'b1;
                end
            end
            if (err) begin
                err_run++;
                if (err_run == MER) begin
                    mode     = M_HUNT;
                    err_run  = 0;
                    exp_lock = 1'b0;
                end
            end
            exp_pulse = err;
            if (clr)                          exp_err = err ? 1 : 0;
            else if (err && exp_err < ERR_MAX) exp_err++;
            if (tog || err) ref_cyc = cyc;
            prev_d = d;
        end
        cyc++;
    endtask

    task automatic step(input bit en, input bit d, input bit clr, input bit rst);
        enable  = en;
        d_in    = d;
        clr_err = clr;
        reset   = rst;
        model_tick(en, d, clr, rst);
        @(posedge clk);
        #1;
        chk("locked", {31'd0, locked}, {31'd0, exp_lock});
        chk("err_pulse", {31'd0, err_pulse}, {31'd0, exp_pulse});
        chk("err_count", 32'(err_count), exp_err);
        chk("good_count", 32'(good_count), exp_good);
        if (err_pulse === 1'b1) pulses_seen++;
        if (locked === 1'b1 && first_lock < 0) first_lock = cyc - 1;
    endtask

    task automatic hold(input int n, input bit en);
        for (int i = 0; i < n; i++) step(en, d_cur, 1'b0, 1'b0);
    endtask

    task automatic toggle_run(input int n_edges, input int gap);
        for (int i = 0; i < n_edges; i++) begin
            d_cur = ~d_cur;
            step(1'b1, d_cur, 1'b0, 1'b0);
            for (int j = 1; j < gap; j++) step(1'b1, d_cur, 1'b0, 1'b0);
        end
    endtask

    task automatic tog_step(input bit clr);
        d_cur = ~d_cur;
        step(1'b1, d_cur, clr, 1'b0);
    endtask

    initial begin
        // Reset state
        d_cur = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        $display("reset: locked=%0b err_pulse=%0b err_count=%0d good_count=%0d",
                 locked, err_pulse, err_count, good_count);

        // Acquire and lock on a clean half-period-2 wave
        hold(4, 1'b1);
        first_lock = -1;
        s0 = cyc;
        toggle_run(8, HP);
        chk("lock_latency", first_lock + 1 - s0, HP * LT + 1);
        chk("good_after_lock", 32'(good_count), 3);
        $display("lock: latency=%0d good_count=%0d", first_lock + 1 - s0, good_count);

        // Missing edges: three flywheel errors two cycles apart, then unlock
        pulses_seen = 0;
        hold(6, 1'b1);
        chk("missing_pulses", pulses_seen, MER);
        chk("missing_errs", 32'(err_count), 3);
        chk("missing_unlock", {31'd0, locked}, 32'd0);
        $display("missing edges: pulses=%0d err_count=%0d locked=%0b", pulses_seen, err_count, locked);

        // Relock, then one early edge followed by an on-time edge
        step(1'b1, d_cur, 1'b1, 1'b0);
        toggle_run(6, HP);
        pulses_seen = 0;
        tog_step(1'b0);
        tog_step(1'b0);
        hold(1, 1'b1);
        tog_step(1'b0);
        hold(1, 1'b1);
        chk("extra_pulses", pulses_seen, 1);
        chk("extra_errs", 32'(err_count), 1);
        chk("extra_good", 32'(good_count), 6);
        chk("extra_locked", {31'd0, locked}, 32'd1);
        $display("extra edge: pulses=%0d err_count=%0d good_count=%0d", pulses_seen, err_count, good_count);

        // Saturate err_count with alternating early/good edges, then clear with an error
        for (int i = 0; i < 260; i++) begin
            tog_step(1'b0);
            tog_step(1'b0);
            hold(1, 1'b1);
        end
        chk("sat_errs", 32'(err_count), ERR_MAX);
        chk("sat_locked", {31'd0, locked}, 32'd1);
        tog_step(1'b0);
        tog_step(1'b1);
        hold(1, 1'b1);
        chk("clr_with_err", 32'(err_count), 1);
        $display("saturation: err_count after clear-with-error=%0d", err_count);

        // Drop enable for one cycle while locked
        tog_step(1'b0);
        hold(1, 1'b1);
        hold(1, 1'b0);
        chk("en_drop_unlock", {31'd0, locked}, 32'd0);
        chk("en_drop_errs", 32'(err_count), 1);
        hold(1, 1'b1);
        toggle_run(4, HP);
        chk("relock_4edges", {31'd0, locked}, 32'd0);
        toggle_run(1, HP);
        chk("relock_5edges", {31'd0, locked}, 32'd1);
        $display("enable drop: relocked=%0b good_count=%0d", locked, good_count);

        // Randomized traffic with occasional clears, enable drops and resets
        gap_left = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_r = ($urandom_range(0, 499) == 0);
            en_r  = ($urandom_range(0, 59) != 0);
            clr_r = ($urandom_range(0, 39) == 0);
            gap_left--;
            if (gap_left == 0) begin
                d_cur = ~d_cur;
                case ($urandom_range(0, 9))
                    0:       gap_left = 1;
                    1:       gap_left = 3;
                    2:       gap_left = 4;
                    default: gap_left = HP;
                endcase
            end
            step(en_r, d_cur, clr_r, rst_r);
        end
        $display("random: err_count=%0d good_count=%0d locked=%0b", err_count, good_count, locked);

        // Reset mid-ACQUIRE with d_in high; no spurious edge afterwards
        d_cur = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        hold(3, 1'b1);
        tog_step(1'b0);
        hold(1, 1'b1);
        step(1'b1, d_cur, 1'b0, 1'b1);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_errs", 32'(err_count), 0);
        chk("rst_good", 32'(good_count), 0);
        pulses_seen = 0;
        first_lock  = -1;
        hold(8, 1'b1);
        chk("no_spurious", pulses_seen, 0);
        s0 = cyc;
        toggle_run(6, HP);
        chk("post_rst_latency", first_lock + 1 - s0, HP * LT + 1);
        $display("reset mid-acquire: pulses=%0d relock latency=%0d", pulses_seen, first_lock + 1 - s0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
